// File: rtl/csr_if.sv
// CSR traffic bundle between the dtcore32 pipeline (master) and the CSR file (slave).
interface csr_if;
    logic [11:0] rd_addr_i;
    logic [31:0] rd_data_o;
    logic        rd_illegal_o;
    logic        wr_valid_i;
    logic [11:0] wr_addr_i;
    logic [31:0] wr_data_i;
    logic        retire_i;
    logic        trap_valid_i;
    logic [31:0] trap_mcause_i;
    logic [31:0] trap_pc_i;
    logic [31:0] trap_vector_o;
    logic        mie_o;

    modport master (
        output rd_addr_i, wr_valid_i, wr_addr_i, wr_data_i, retire_i,
               trap_valid_i, trap_mcause_i, trap_pc_i,
        input  rd_data_o, rd_illegal_o, trap_vector_o, mie_o
    );

    modport slave (
        input  rd_addr_i, wr_valid_i, wr_addr_i, wr_data_i, retire_i,
               trap_valid_i, trap_mcause_i, trap_pc_i,
        output rd_data_o, rd_illegal_o, trap_vector_o, mie_o
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file for dtcore32: combinational read port, WB write/trap commit, 64-bit counters.
// Define CSR_COUNTERS_EN to implement mcycle/minstret; otherwise those addresses read as legal zeros.
module csr_file #(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic clk_i,
    input  logic rst_ni,
    csr_if.slave bus
);
    localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;
    localparam logic [31:0] MISA_VAL      = 32'h4000_0100;

    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic        wr_en;

    // Legalised value a write would leave in the CSR at address a.
    function automatic logic [31:0] warl(input logic [11:0] a, input logic [31:0] d);
        case (a)
            12'h300:          warl = MSTATUS_FIXED | (d & 32'h0000_0088);
            12'h304:          warl = d & 32'h0000_0888;
            12'h305, 12'h341: warl = {d[31:2], 2'b00};
            default:          warl = d;
        endcase
    endfunction

    function automatic logic writable(input logic [11:0] a);
        case (a)
            12'h300, 12'h304, 12'h305,
            12'h340, 12'h341, 12'h342, 12'h343: writable = 1'b1;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hB02, 12'hB80, 12'hB82: writable = 1'b1;
`endif
            default:                            writable = 1'b0;
        endcase
    endfunction

    assign wr_en = bus.wr_valid_i && !bus.trap_valid_i;

    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        if (bus.trap_valid_i) begin
            mstatus_d = MSTATUS_FIXED | {24'd0, mstatus_q[3], 7'd0};
            mepc_d    = warl(12'h341, bus.trap_pc_i);
            mcause_d  = bus.trap_mcause_i;
            mtval_d   = 32'd0;
        end else if (bus.wr_valid_i) begin
            case (bus.wr_addr_i)
                12'h300: mstatus_d  = warl(bus.wr_addr_i, bus.wr_data_i);
                12'h304: mie_d      = warl(bus.wr_addr_i, bus.wr_data_i);
                12'h305: mtvec_d    = warl(bus.wr_addr_i, bus.wr_data_i);
                12'h340: mscratch_d = bus.wr_data_i;
                12'h341: mepc_d     = warl(bus.wr_addr_i, bus.wr_data_i);
                12'h342: mcause_d   = bus.wr_data_i;
                12'h343: mtval_d    = bus.wr_data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mstatus_q  <= MSTATUS_FIXED;
            mie_q      <= 32'd0;
            mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
            mscratch_q <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mtval_q    <= 32'd0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    // A write to either half freezes that counter for the cycle.
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, bus.retire_i};
        if (wr_en) begin
            case (bus.wr_addr_i)
                12'hB00: mcycle_d   = {mcycle_q[63:32], bus.wr_data_i};
                12'hB80: mcycle_d   = {bus.wr_data_i, mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[63:32], bus.wr_data_i};
                12'hB82: minstret_d = {bus.wr_data_i, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`else
    logic unused_retire;
    assign unused_retire = bus.retire_i;
`endif

    logic [31:0] rd_val;
    logic        rd_bad;

    always_comb begin
        rd_val = 32'd0;
        rd_bad = 1'b0;
        case (bus.rd_addr_i)
            12'h300: rd_val = mstatus_q;
            12'h301: rd_val = MISA_VAL;
            12'h304: rd_val = mie_q;
            12'h305: rd_val = mtvec_q;
            12'h340: rd_val = mscratch_q;
            12'h341: rd_val = mepc_q;
            12'h342: rd_val = mcause_q;
            12'h343: rd_val = mtval_q;
            12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF15: rd_val = 32'd0;
            12'hF14: rd_val = HART_ID;
`ifdef CSR_COUNTERS_EN
            12'hB00: rd_val = mcycle_q[31:0];
            12'hB80: rd_val = mcycle_q[63:32];
            12'hB02: rd_val = minstret_q[31:0];
            12'hB82: rd_val = minstret_q[63:32];
`else
            12'hB00, 12'hB02, 12'hB80, 12'hB82: rd_val = 32'd0;
`endif
            default: rd_bad = 1'b1;
        endcase
        if (wr_en && bus.wr_addr_i == bus.rd_addr_i && writable(bus.wr_addr_i))
            rd_val = warl(bus.wr_addr_i, bus.wr_data_i);
    end

    assign bus.rd_data_o     = rd_val;
    assign bus.rd_illegal_o  = rd_bad;
    assign bus.trap_vector_o = mtvec_q;
    assign bus.mie_o         = mstatus_q[3];
endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: vector table for single-cycle CSR accesses plus trap, counter and reset sequences.
module tb_csr_file;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int total = 0;
    int bad = 0;

    csr_if bus ();

    csr_file #(.HART_ID(32'd3), .MTVEC_RESET(32'h0000_0103)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        wv;
        logic [11:0] wa;
        logic [31:0] wd;
        logic [11:0] ra;
        logic [31:0] exp_rd;
        logic        exp_ill;
        logic [31:0] exp_tvec;
        logic        exp_mie;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wr_valid_i    = 1'b0;
        bus.wr_addr_i     = 12'h000;
        bus.wr_data_i     = 32'd0;
        bus.retire_i      = 1'b0;
        bus.trap_valid_i  = 1'b0;
        bus.trap_mcause_i = 32'd0;
        bus.trap_pc_i     = 32'd0;
        bus.rd_addr_i     = 12'h300;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rd_check(input string name, input logic [11:0] a, input logic [31:0] exp,
                            input logic exp_ill);
        bus.rd_addr_i = a;
        #1;
        check({name, "_data"}, bus.rd_data_o, exp);
        check({name, "_ill"}, {31'd0, bus.rd_illegal_o}, {31'd0, exp_ill});
    endtask

    initial begin
        vecs[0]  = '{1'b0, 12'h000, 32'h0,        12'h300, 32'h0000_1800, 1'b0, 32'h0000_0100, 1'b0};
        vecs[1]  = '{1'b0, 12'h000, 32'h0,        12'h301, 32'h4000_0100, 1'b0, 32'h0000_0100, 1'b0};
        vecs[2]  = '{1'b0, 12'h000, 32'h0,        12'hF14, 32'h0000_0003, 1'b0, 32'h0000_0100, 1'b0};
        vecs[3]  = '{1'b0, 12'h000, 32'h0,        12'h305, 32'h0000_0100, 1'b0, 32'h0000_0100, 1'b0};
        vecs[4]  = '{1'b1, 12'h305, 32'h8000_0107, 12'h305, 32'h8000_0104, 1'b0, 32'h0000_0100, 1'b0};
        vecs[5]  = '{1'b0, 12'h000, 32'h0,        12'h305, 32'h8000_0104, 1'b0, 32'h8000_0104, 1'b0};
        vecs[6]  = '{1'b0, 12'h000, 32'h0,        12'h7C0, 32'h0000_0000, 1'b1, 32'h8000_0104, 1'b0};
        vecs[7]  = '{1'b1, 12'h300, 32'hFFFF_FFFF, 12'h300, 32'h0000_1888, 1'b0, 32'h8000_0104, 1'b0};
        vecs[8]  = '{1'b0, 12'h000, 32'h0,        12'h300, 32'h0000_1888, 1'b0, 32'h8000_0104, 1'b1};
        vecs[9]  = '{1'b1, 12'h304, 32'hFFFF_FFFF, 12'h304, 32'h0000_0888, 1'b0, 32'h8000_0104, 1'b1};
        vecs[10] = '{1'b0, 12'h000, 32'h0,        12'h304, 32'h0000_0888, 1'b0, 32'h8000_0104, 1'b1};
        vecs[11] = '{1'b1, 12'h301, 32'h0000_1234, 12'h301, 32'h4000_0100, 1'b0, 32'h8000_0104, 1'b1};
        vecs[12] = '{1'b1, 12'h341, 32'h0000_0013, 12'h341, 32'h0000_0010, 1'b0, 32'h8000_0104, 1'b1};
        vecs[13] = '{1'b1, 12'h340, 32'hCAFE_BABE, 12'h341, 32'h0000_0010, 1'b0, 32'h8000_0104, 1'b1};
        vecs[14] = '{1'b0, 12'h000, 32'h0,        12'h340, 32'hCAFE_BABE, 1'b0, 32'h8000_0104, 1'b1};
        vecs[15] = '{1'b1, 12'h343, 32'h0000_0055, 12'h343, 32'h0000_0055, 1'b0, 32'h8000_0104, 1'b1};
        vecs[16] = '{1'b0, 12'h000, 32'h0,        12'h344, 32'h0000_0000, 1'b0, 32'h8000_0104, 1'b1};
        vecs[17] = '{1'b0, 12'h000, 32'h0,        12'hF11, 32'h0000_0000, 1'b0, 32'h8000_0104, 1'b1};
        vecs[18] = '{1'b1, 12'h300, 32'h0000_0008, 12'h300, 32'h0000_1808, 1'b0, 32'h8000_0104, 1'b1};
        vecs[19] = '{1'b0, 12'h000, 32'h0,        12'h300, 32'h0000_1808, 1'b0, 32'h8000_0104, 1'b1};

        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) tick();
        rst_ni = 1'b1;

        for (int i = 0; i < 20; i++) begin
            bus.wr_valid_i = vecs[i].wv;
            bus.wr_addr_i  = vecs[i].wa;
            bus.wr_data_i  = vecs[i].wd;
            bus.rd_addr_i  = vecs[i].ra;
            #1;
            check($sformatf("vec%0d_rd", i), bus.rd_data_o, vecs[i].exp_rd);
            check($sformatf("vec%0d_ill", i), {31'd0, bus.rd_illegal_o}, {31'd0, vecs[i].exp_ill});
            check($sformatf("vec%0d_tvec", i), bus.trap_vector_o, vecs[i].exp_tvec);
            check($sformatf("vec%0d_mie", i), {31'd0, bus.mie_o}, {31'd0, vecs[i].exp_mie});
            tick();
        end
        idle_inputs();

        // Trap with a competing mepc write: bypass suppressed, write dropped.
        bus.trap_valid_i  = 1'b1;
        bus.trap_pc_i     = 32'h0000_1236;
        bus.trap_mcause_i = 32'd11;
        bus.wr_valid_i    = 1'b1;
        bus.wr_addr_i     = 12'h341;
        bus.wr_data_i     = 32'h0000_DEAD;
        rd_check("trap_nobypass", 12'h341, 32'h0000_0010, 1'b0);
        tick();
        idle_inputs();
        rd_check("trap_mepc", 12'h341, 32'h0000_1234, 1'b0);
        rd_check("trap_mcause", 12'h342, 32'd11, 1'b0);
        rd_check("trap_mtval", 12'h343, 32'd0, 1'b0);
        rd_check("trap_mstatus", 12'h300, 32'h0000_1880, 1'b0);
        check("trap_mie_o", {31'd0, bus.mie_o}, 32'd0);
        check("trap_tvec", bus.trap_vector_o, 32'h8000_0104);

`ifdef CSR_COUNTERS_EN
        // mcycle carry from low to high half.
        bus.wr_valid_i = 1'b1;
        bus.wr_addr_i  = 12'hB00;
        bus.wr_data_i  = 32'hFFFF_FFFF;
        tick();
        bus.wr_addr_i  = 12'hB80;
        bus.wr_data_i  = 32'd0;
        tick();
        idle_inputs();
        repeat (2) tick();
        rd_check("mcycleh", 12'hB80, 32'd1, 1'b0);
        rd_check("mcycle", 12'hB00, 32'd1, 1'b0);

        // minstret write wins over a concurrent retire.
        bus.retire_i   = 1'b1;
        bus.wr_valid_i = 1'b1;
        bus.wr_addr_i  = 12'hB02;
        bus.wr_data_i  = 32'd5;
        rd_check("minstret_bypass", 12'hB02, 32'd5, 1'b0);
        tick();
        bus.wr_valid_i = 1'b0;
        rd_check("minstret_wr", 12'hB02, 32'd5, 1'b0);
        tick();
        rd_check("minstret_inc", 12'hB02, 32'd6, 1'b0);
        bus.trap_valid_i  = 1'b1;
        bus.trap_pc_i     = 32'h0000_2000;
        bus.trap_mcause_i = 32'd2;
        tick();
        idle_inputs();
        rd_check("minstret_trap", 12'hB02, 32'd7, 1'b0);
        rd_check("minstreth", 12'hB82, 32'd0, 1'b0);
`else
        bus.wr_valid_i = 1'b1;
        bus.wr_addr_i  = 12'hB00;
        bus.wr_data_i  = 32'h1234_5678;
        bus.retire_i   = 1'b1;
        rd_check("cnt_off_bypass", 12'hB00, 32'd0, 1'b0);
        tick();
        idle_inputs();
        rd_check("cnt_off_b00", 12'hB00, 32'd0, 1'b0);
        rd_check("cnt_off_b02", 12'hB02, 32'd0, 1'b0);
        rd_check("cnt_off_b80", 12'hB80, 32'd0, 1'b0);
        rd_check("cnt_off_b82", 12'hB82, 32'd0, 1'b0);
`endif

        // Reset overrides a concurrent mscratch write.
        bus.wr_valid_i = 1'b1;
        bus.wr_addr_i  = 12'h340;
        bus.wr_data_i  = 32'h0000_1234;
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        idle_inputs();
        rd_check("rst_mscratch", 12'h340, 32'd0, 1'b0);
        rd_check("rst_mepc", 12'h341, 32'd0, 1'b0);
        rd_check("rst_mcause", 12'h342, 32'd0, 1'b0);
        rd_check("rst_mie", 12'h304, 32'd0, 1'b0);
        rd_check("rst_mstatus", 12'h300, 32'h0000_1800, 1'b0);
        check("rst_tvec", bus.trap_vector_o, 32'h0000_0100);
        check("rst_mie_o", {31'd0, bus.mie_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
